uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 21 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 136 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and serial line levels
// used by both uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: line/tick inputs and the received-word outputs.
interface uart_rx_if #(
  parameter int unsigned SIZE = 7
);
  logic          ce;
  logic          rx;
  logic          data_valid;
  logic [SIZE:0] data_byte;
  logic          active;
  logic          frame_error;

  modport master (
    output ce, rx,
    input  data_valid, data_byte, active, frame_error
  );

  modport slave (
    input  ce, rx,
    output data_valid, data_byte, active, frame_error
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value selectable.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {2{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling on ce ticks, LSB first, one stop bit,
// single-cycle valid / frame-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SIZE         = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          i_rx,
  output logic          o_data_valid,
  output logic [SIZE:0] o_data_byte,
  output logic          o_active,
  output logic          o_frame_error
);

  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = $clog2(SIZE + 1);

  localparam logic [TICK_W-1:0] HALF_M1  = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_M1  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SIZE);

  logic w_rx_s;

  sync_2ff #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (i_rx),
    .o_q   (w_rx_s)
  );

  uart_rx_state_t    r_state, w_state_nx;
  logic [TICK_W-1:0] r_tick,  w_tick_nx;
  logic [IDX_W-1:0]  r_idx,   w_idx_nx;
  logic [SIZE:0]     r_shift, w_shift_nx;
  logic [SIZE:0]     r_data,  w_data_nx;
  logic              r_valid, w_valid_nx;
  logic              r_ferr,  w_ferr_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_tick  <= w_tick_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_data  <= w_data_nx;
      r_valid <= w_valid_nx;
      r_ferr  <= w_ferr_nx;
    end
  end

  // Pulses default low every clk so they stay one cycle wide even when ce is sparse.
  always_comb begin
    w_state_nx = r_state;
    w_tick_nx  = r_tick;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_data_nx  = r_data;
    w_valid_nx = 1'b0;
    w_ferr_nx  = 1'b0;
    if (ce) begin
      unique case (r_state)
        IDLE: begin
          if (w_rx_s == UART_START_LEVEL) begin
            w_state_nx = START;
            w_tick_nx  = '0;
          end
        end
        START: begin
          if (r_tick == HALF_M1) begin
            w_tick_nx = '0;
            if (w_rx_s == UART_START_LEVEL) begin
              w_state_nx = DATA;
              w_idx_nx   = '0;
            end else begin
              w_state_nx = IDLE;
            end
          end else begin
            w_tick_nx = r_tick + 1'b1;
          end
        end
        DATA: begin
          if (r_tick == FULL_M1) begin
            w_tick_nx           = '0;
            w_shift_nx[r_idx]   = w_rx_s;
            if (r_idx == LAST_IDX) begin
              w_state_nx = STOP;
            end else begin
              w_idx_nx = r_idx + 1'b1;
            end
          end else begin
            w_tick_nx = r_tick + 1'b1;
          end
        end
        STOP: begin
          if (r_tick == FULL_M1) begin
            w_tick_nx = '0;
            if (w_rx_s == UART_STOP_LEVEL) begin
              w_data_nx  = r_shift;
              w_valid_nx = 1'b1;
              w_state_nx = IDLE;
            end else begin
              w_ferr_nx  = 1'b1;
              w_state_nx = WAIT_IDLE;
            end
          end else begin
            w_tick_nx = r_tick + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (w_rx_s == UART_IDLE_LEVEL) begin
            w_state_nx = IDLE;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  assign o_active      = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign o_data_valid  = r_valid;
  assign o_frame_error = r_ferr;
  assign o_data_byte   = r_data;

endmodule
